imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//   Boot-time writer for the instruction memory that the core fetches from. Receives a
//   framed byte stream over a valid/ready interface and assembles little-endian 32-bit
//   words. Writes each word to consecutive instruction-memory word addresses.
//   Holds the core in reset until a complete, checksum-verified image is loaded.
// PARAMETERS
//   ADDR_W  11  instruction-memory word-address width; depth = 2**ADDR_W words
// PORTS
//   clk          in   1       clock
//   reset        in   1       synchronous, active-low reset
//   start        in   1       begin load; honoured only in IDLE, DONE or ERROR
//   in_valid     in   1       stream byte valid
//   in_data      in   8       stream byte
//   in_ready     out  1       loader accepts byte this cycle
//   mem_we       out  1       instruction-memory write strobe (one cycle per word)
//   mem_addr     out  ADDR_W  word address of write
//   mem_wdata    out  32      word to write
//   cpu_reset    out  1       active-high hold for the core; 0 only in DONE
//   busy         out  1       load in progress (states LEN_LO..CSUM)
//   done         out  1       image loaded and verified
//   error        out  1       length or checksum failure
//   words_loaded out  16      count of mem_we pulses since last start
// BEHAVIOUR
//   Frame: LEN_LO, LEN_HI (N = 16-bit word count, LE), 4*N data bytes (LE per word),
//     then 1 checksum byte = XOR of all 4*N data bytes.
//   Byte accepted iff in_valid & in_ready. in_ready is 1 only in LEN_LO/LEN_HI/DATA/CSUM.
//   While reset is low, on the next clk edge: state=IDLE; in_ready=0, mem_we=0,
//     mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0, error=0, words_loaded=0.
//   States / transitions:
//     IDLE   : start -> LEN_LO.
//     LEN_LO : accept -> N[7:0], LEN_HI.
//     LEN_HI : accept -> N[15:8]. N > 2**ADDR_W -> ERROR; N == 0 -> CSUM; else DATA.
//     DATA   : byte_idx 0..3 and word_idx count up. On accept of byte 3:
//                next cycle mem_we=1, mem_addr=word_idx, mem_wdata={b3,b2,b1,b0},
//                words_loaded+1.
//              After word N-1's byte 3 -> CSUM.
//     CSUM   : accept; byte == running XOR -> DONE, else ERROR.
//     DONE   : done=1, cpu_reset=0, in_ready=0; start -> LEN_LO.
//     ERROR  : error=1, cpu_reset=1, in_ready=0; start -> LEN_LO.
//   On start from DONE/ERROR: cpu_reset=1, done/error cleared, XOR/counters/words_loaded
//     cleared, all in the same edge as entry to LEN_LO. start while busy is ignored.
//   mem_we, mem_addr, mem_wdata are registered. mem_addr/mem_wdata hold their last value
//     when mem_we=0.
//   Word output register is separate from the byte assembler, so in_ready stays 1 during
//     the mem_we cycle. Back-to-back accepts sustain 1 byte/cycle with no bubbles.
//   in_valid low stalls progress indefinitely. No state or counter changes on cycles
//     without an accept (other than the mem_we pulse).
//   mem_we is never asserted outside the cycle after a byte-3 accept.
//   No write occurs for a partial word.
//   N == 2**ADDR_W is legal: last write at mem_addr = all ones, no wrap.
//   Checksum failure does not undo completed writes.
//   cpu_reset is registered: it falls the cycle DONE is entered and rises the cycle
//     LEN_LO is entered.
//   Reset low mid-frame: abort to IDLE, no further mem_we, partial word discarded.
// TESTING
//   1. start; bytes 02 00 | 13 00 00 00 | B3 00 50 00 | F0
//      -> mem_we@0=0x00000013, mem_we@1=0x005000B3; done=1, cpu_reset=0, words_loaded=2.
//   2. Same frame with checksum 00
//      -> both writes occur; error=1, done=0, cpu_reset=1, in_ready=0.
//   3. start; bytes 00 00 | 00
//      -> no mem_we; done=1. Separately, checksum 01 -> error=1.
//   4. ADDR_W=11; header 01 08 (N=0x0801)
//      -> ERROR the cycle after LEN_HI accept; no mem_we.
//   5. Frame of test 1 with in_valid toggling every other cycle, plus start pulses while
//      busy -> identical writes, exactly 2 mem_we pulses.
//   6. reset low for 1 cycle after 2 DATA bytes -> IDLE, cpu_reset=1, no mem_we.
//      start + test-1 frame then loads cleanly.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Takes a framed byte stream (16-bit LE word count, 4*N LE data bytes, XOR
// checksum byte), writes each assembled word to consecutive word addresses,
// and holds the core in reset until a complete image has been verified.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | after reset, waiting for start
// LEN_LO  | expecting low byte of the word count
// LEN_HI  | expecting high byte of the word count; range-checked here
// DATA    | assembling data bytes into words, one write per 4th byte
// CSUM    | expecting the checksum byte
// DONE    | image verified; core released
// ERROR   | length or checksum failure; core held in reset
module imem_loader #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q;
  logic [15:0]         len_q;
  logic [1:0]          byte_idx_q;
  logic [ADDR_W-1:0]   word_idx_q;
  logic [23:0]         asm_q;
  logic [7:0]          xor_q;
  logic                in_ready_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic                cpu_reset_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic [15:0]         words_loaded_q;

  logic                accept;
  logic [15:0]         len_d;
  logic [31:0]         word_d;
  logic                last_word;

  // Byte handshake, candidate length and the word completed by the current byte.
  always_comb begin
    accept    = in_valid & in_ready_q;
    len_d     = {in_data, len_q[7:0]};
    // asm_q is a shift register, so after three bytes it holds {b2,b1,b0}.
    word_d    = {in_data, asm_q};
    last_word = ((32'(word_idx_q) + 32'd1) == 32'(len_q));
  end

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      byte_idx_q     <= '0;
      word_idx_q     <= '0;
      asm_q          <= '0;
      xor_q          <= '0;
      in_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_reset_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q        <= S_LEN_LO;
            in_ready_q     <= 1'b1;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            cpu_reset_q    <= 1'b1;
            xor_q          <= '0;
            byte_idx_q     <= '0;
            word_idx_q     <= '0;
            words_loaded_q <= '0;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            len_q[7:0] <= in_data;
            state_q    <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            len_q <= len_d;
            if (32'(len_d) > DEPTH) begin
              state_q    <= S_ERROR;
              error_q    <= 1'b1;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
            end else if (len_d == 16'd0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            xor_q      <= xor_q ^ in_data;
            asm_q      <= {in_data, asm_q[23:8]};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              mem_we_q       <= 1'b1;
              mem_addr_q     <= word_idx_q;
              mem_wdata_q    <= word_d;
              words_loaded_q <= words_loaded_q + 16'd1;
              // Wraps to 0 only after the final word of a full-depth image,
              // and is cleared again on the next start.
              word_idx_q     <= word_idx_q + 1'b1;
              if (last_word) begin
                state_q <= S_CSUM;
              end
            end
          end
        end

        S_CSUM: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (in_data == xor_q) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Drive ports straight from their registers.
  always_comb begin
    in_ready     = in_ready_q;
    mem_we       = mem_we_q;
    mem_addr     = mem_addr_q;
    mem_wdata    = mem_wdata_q;
    cpu_reset    = cpu_reset_q;
    busy         = busy_q;
    done         = done_q;
    error        = error_q;
    words_loaded = words_loaded_q;
  end

endmodule
